// File: rtl/spi_copy_sequencer_pkg.sv
// Shared definitions for the ROM A to ROM B flash copy sequencer.
package spi_copy_sequencer_pkg;

    localparam int unsigned PAGE_BYTES_DEF   = 256;
    localparam int unsigned SECTOR_BYTES_DEF = 4096;
    localparam int unsigned LEN_W            = 9;

    typedef enum logic [3:0] {
        StIdle,
        StSettle,
        StChunk,
        StErase,
        StWaitEr,
        StRead,
        StWaitRd,
        StProg,
        StWaitPp,
        StNext,
        StDone,
        StFail
    } copy_state_e;

endpackage

// File: rtl/spi_wait_timer.sv
// Loadable down-counter shared by the mux settle delay and the engine watchdog.
// expired is high whenever the count sits at zero.
module spi_wait_timer
    import spi_copy_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = 25
) (
    input  logic             system_clk,
    input  logic             system_reset_n,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic             expired
);

    logic [WIDTH-1:0] count_q;

    // Count down while enabled; clear wins over load, load wins over counting.
    always_ff @(posedge system_clk or negedge system_reset_n) begin
        if (!system_reset_n) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_value;
        end else if (enable && (count_q != '0)) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

    assign expired = (count_q == '0);

endmodule

// File: rtl/spi_copy_sequencer.sv
// Copies an inclusive byte range from flash ROM A to ROM B in page-aligned chunks,
// erasing each destination sector once before its first program.
module spi_copy_sequencer
    import spi_copy_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned PAGE_BYTES   = PAGE_BYTES_DEF,
    parameter int unsigned SECTOR_BYTES = SECTOR_BYTES_DEF,
    parameter int unsigned SETTLE_CYC   = 16,
    parameter int unsigned TIMEOUT_CYC  = 1 << 24
) (
    input  logic              system_clk,
    input  logic              system_reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] src_start_addr,
    input  logic [ADDR_W-1:0] src_end_addr,
    input  logic [ADDR_W-1:0] dst_start_addr,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [LEN_W-1:0]  rd_len,
    input  logic              rd_done,
    output logic              er_req,
    output logic [ADDR_W-1:0] er_addr,
    input  logic              er_done,
    output logic              pp_req,
    output logic [ADDR_W-1:0] pp_addr,
    output logic [LEN_W-1:0]  pp_len,
    input  logic              pp_done,
    output logic              mux_sel,
    output logic              busy_n,
    output logic              completed_n,
    output logic              error
);

    localparam int unsigned MAX_WAIT = (SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC;
    localparam int unsigned TMR_W    = $clog2(MAX_WAIT + 1);

    localparam logic [ADDR_W-1:0] PAGE_MASK   = ADDR_W'(PAGE_BYTES - 1);
    localparam logic [ADDR_W-1:0] SECTOR_MASK = ADDR_W'(SECTOR_BYTES - 1);
    localparam logic [ADDR_W:0]   PAGE_SPAN   = (ADDR_W+1)'(PAGE_BYTES);

    copy_state_e       state_q;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    // One extra bit so a full address-space span is representable.
    logic [ADDR_W:0]   remaining_q;
    logic [LEN_W-1:0]  len_q;
    logic [ADDR_W-1:0] last_erased_q;
    logic              first_chunk_q;

    logic [ADDR_W:0]   page_room;
    logic [ADDR_W:0]   chunk_wide;
    logic [LEN_W-1:0]  chunk_len;
    logic [ADDR_W-1:0] sector_base;
    logic              need_erase;
    logic              abort_hit;

    logic              tmr_clear;
    logic              tmr_load;
    logic [TMR_W-1:0]  tmr_value;
    logic              tmr_enable;
    logic              tmr_expired;

    // Chunk size is capped by the bytes left in the current destination page.
    always_comb begin
        page_room   = PAGE_SPAN - {1'b0, dst_q & PAGE_MASK};
        chunk_wide  = (remaining_q < page_room) ? remaining_q : page_room;
        chunk_len   = LEN_W'(chunk_wide);
        sector_base = dst_q & ~SECTOR_MASK;
        need_erase  = first_chunk_q || (sector_base != last_erased_q);
        abort_hit   = abort && (state_q != StIdle) && (state_q != StDone) &&
                      (state_q != StFail);
    end

    // Timer is armed for the settle delay on start and for the watchdog on each
    // request, so it holds a fresh full budget on entry to every wait state.
    always_comb begin
        tmr_clear  = 1'b0;
        tmr_load   = 1'b0;
        tmr_value  = '0;
        tmr_enable = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    tmr_load  = 1'b1;
                    tmr_value = TMR_W'(SETTLE_CYC - 1);
                end
            end
            StErase, StRead, StProg: begin
                tmr_load  = 1'b1;
                tmr_value = TMR_W'(TIMEOUT_CYC - 1);
            end
            StSettle, StWaitEr, StWaitRd, StWaitPp: tmr_enable = 1'b1;
            StDone, StFail:                         tmr_clear  = 1'b1;
            default: ;
        endcase
    end

    spi_wait_timer #(
        .WIDTH (TMR_W)
    ) u_wait_timer (
        .system_clk     (system_clk),
        .system_reset_n (system_reset_n),
        .clear          (tmr_clear),
        .load           (tmr_load),
        .load_value     (tmr_value),
        .enable         (tmr_enable),
        .expired        (tmr_expired)
    );

    // Sequencer FSM with registered request, address and status outputs.
    always_ff @(posedge system_clk or negedge system_reset_n) begin
        if (!system_reset_n) begin
            state_q       <= StIdle;
            src_q         <= '0;
            dst_q         <= '0;
            remaining_q   <= '0;
            len_q         <= '0;
            last_erased_q <= '0;
            first_chunk_q <= 1'b1;
            rd_req        <= 1'b0;
            rd_addr       <= '0;
            rd_len        <= '0;
            er_req        <= 1'b0;
            er_addr       <= '0;
            pp_req        <= 1'b0;
            pp_addr       <= '0;
            pp_len        <= '0;
            mux_sel       <= 1'b0;
            busy_n        <= 1'b1;
            completed_n   <= 1'b1;
            error         <= 1'b0;
        end else begin
            // Requests are single-cycle pulses.
            rd_req <= 1'b0;
            er_req <= 1'b0;
            pp_req <= 1'b0;
            if (abort_hit) begin
                state_q <= StFail;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (start) begin
                            src_q         <= src_start_addr;
                            dst_q         <= dst_start_addr;
                            first_chunk_q <= 1'b1;
                            completed_n   <= 1'b1;
                            error         <= 1'b0;
                            if (src_end_addr < src_start_addr) begin
                                state_q <= StFail;
                            end else begin
                                remaining_q <= {1'b0, src_end_addr} - {1'b0, src_start_addr} +
                                               (ADDR_W+1)'(1);
                                mux_sel     <= 1'b1;
                                busy_n      <= 1'b0;
                                state_q     <= StSettle;
                            end
                        end
                    end
                    StSettle: begin
                        if (tmr_expired) state_q <= StChunk;
                    end
                    StChunk: begin
                        len_q   <= chunk_len;
                        state_q <= need_erase ? StErase : StRead;
                    end
                    StErase: begin
                        er_req  <= 1'b1;
                        er_addr <= sector_base;
                        state_q <= StWaitEr;
                    end
                    StWaitEr: begin
                        // A done coinciding with the request cycle cannot be a response.
                        if (er_done && !er_req) begin
                            last_erased_q <= er_addr;
                            first_chunk_q <= 1'b0;
                            state_q       <= StRead;
                        end else if (tmr_expired) begin
                            state_q <= StFail;
                        end
                    end
                    StRead: begin
                        rd_req  <= 1'b1;
                        rd_addr <= src_q;
                        rd_len  <= len_q;
                        state_q <= StWaitRd;
                    end
                    StWaitRd: begin
                        if (rd_done && !rd_req) state_q <= StProg;
                        else if (tmr_expired)   state_q <= StFail;
                    end
                    StProg: begin
                        pp_req  <= 1'b1;
                        pp_addr <= dst_q;
                        pp_len  <= len_q;
                        state_q <= StWaitPp;
                    end
                    StWaitPp: begin
                        if (pp_done && !pp_req) state_q <= StNext;
                        else if (tmr_expired)   state_q <= StFail;
                    end
                    StNext: begin
                        src_q       <= src_q + ADDR_W'(len_q);
                        dst_q       <= dst_q + ADDR_W'(len_q);
                        remaining_q <= remaining_q - (ADDR_W+1)'(len_q);
                        state_q     <= (remaining_q == (ADDR_W+1)'(len_q)) ? StDone : StChunk;
                    end
                    StDone: begin
                        mux_sel     <= 1'b0;
                        busy_n      <= 1'b1;
                        completed_n <= 1'b0;
                        state_q     <= StIdle;
                    end
                    StFail: begin
                        mux_sel <= 1'b0;
                        busy_n  <= 1'b1;
                        error   <= 1'b1;
                        state_q <= StIdle;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_copy_sequencer.sv
// Self-checking bench for spi_copy_sequencer: randomized copies against a
// byte-range reference model, plus directed error, timeout and abort scenarios.
module tb_spi_copy_sequencer;

    localparam int unsigned SETTLE  = 4;
    localparam int unsigned TIMEOUT = 100;

    logic        system_clk = 1'b0;
    logic        system_reset_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] src_start_addr = '0;
    logic [31:0] src_end_addr = '0;
    logic [31:0] dst_start_addr = '0;
    logic        rd_req, er_req, pp_req;
    logic [31:0] rd_addr, er_addr, pp_addr;
    logic [8:0]  rd_len, pp_len;
    logic        rd_done, er_done, pp_done;
    logic        mux_sel, busy_n, completed_n, error;

    logic rd_done_auto = 1'b0, er_done_auto = 1'b0, pp_done_auto = 1'b0;
    logic rd_done_man = 1'b0;
    assign rd_done = rd_done_auto | rd_done_man;
    assign er_done = er_done_auto;
    assign pp_done = pp_done_auto;

    always #5 system_clk = ~system_clk;

    spi_copy_sequencer #(
        .ADDR_W       (32),
        .PAGE_BYTES   (256),
        .SECTOR_BYTES (4096),
        .SETTLE_CYC   (SETTLE),
        .TIMEOUT_CYC  (TIMEOUT)
    ) dut (
        .system_clk     (system_clk),
        .system_reset_n (system_reset_n),
        .start          (start),
        .abort          (abort),
        .src_start_addr (src_start_addr),
        .src_end_addr   (src_end_addr),
        .dst_start_addr (dst_start_addr),
        .rd_req         (rd_req),
        .rd_addr        (rd_addr),
        .rd_len         (rd_len),
        .rd_done        (rd_done),
        .er_req         (er_req),
        .er_addr        (er_addr),
        .er_done        (er_done),
        .pp_req         (pp_req),
        .pp_addr        (pp_addr),
        .pp_len         (pp_len),
        .pp_done        (pp_done),
        .mux_sel        (mux_sel),
        .busy_n         (busy_n),
        .completed_n    (completed_n),
        .error          (error)
    );

    int tests = 0;
    int failed = 0;

    bit auto_rd = 1'b1, auto_er = 1'b1, auto_pp = 1'b1;
    int rd_lat, er_lat, pp_lat;

    // Observed requests.
    logic [31:0] er_log[$];
    logic [31:0] rd_addr_log[$];
    logic [31:0] pp_addr_log[$];
    int          rd_len_log[$];
    int          pp_len_log[$];
    // Expected requests from the reference model.
    logic [31:0] exp_er[$];
    logic [31:0] exp_rd_addr[$];
    logic [31:0] exp_pp_addr[$];
    int          exp_len[$];

    int          bad_pulse = 0;
    bit          saw_busy, saw_mux, saw_busy_low;
    logic        prev_rd = 1'b0, prev_er = 1'b0, prev_pp = 1'b0;
    logic [31:0] hold_rd_addr = '0, hold_er_addr = '0, hold_pp_addr = '0;
    logic [8:0]  hold_rd_len = '0, hold_pp_len = '0;

    // Directed copies: inclusive source range, destination, expected erase and chunk counts.
    logic [31:0] d_src[3] = '{32'h0100_0F00, 32'h0000_0000, 32'h0000_0000};
    logic [31:0] d_end[3] = '{32'h0100_0F05, 32'h0000_02FF, 32'h0000_00FF};
    logic [31:0] d_dst[3] = '{32'h0300_0000, 32'h0000_0080, 32'h0000_0F80};
    int          d_ner[3] = '{1, 1, 2};
    int          d_nch[3] = '{1, 4, 2};

    // Request monitor: logs requests, flags wide pulses and addr/len changing before done.
    initial begin
        forever begin
            @(negedge system_clk);
            if (rd_req) begin
                if (prev_rd) bad_pulse++;
                rd_addr_log.push_back(rd_addr);
                rd_len_log.push_back(int'(rd_len));
                hold_rd_addr = rd_addr;
                hold_rd_len  = rd_len;
            end
            if (er_req) begin
                if (prev_er) bad_pulse++;
                er_log.push_back(er_addr);
                hold_er_addr = er_addr;
            end
            if (pp_req) begin
                if (prev_pp) bad_pulse++;
                pp_addr_log.push_back(pp_addr);
                pp_len_log.push_back(int'(pp_len));
                hold_pp_addr = pp_addr;
                hold_pp_len  = pp_len;
            end
            if (rd_done && !rd_req && (rd_addr !== hold_rd_addr || rd_len !== hold_rd_len))
                bad_pulse++;
            if (er_done && !er_req && er_addr !== hold_er_addr) bad_pulse++;
            if (pp_done && !pp_req && (pp_addr !== hold_pp_addr || pp_len !== hold_pp_len))
                bad_pulse++;
            if (!busy_n && mux_sel) saw_busy = 1'b1;
            if (mux_sel) saw_mux = 1'b1;
            if (!busy_n) saw_busy_low = 1'b1;
            prev_rd = rd_req;
            prev_er = er_req;
            prev_pp = pp_req;
        end
    end

    // Engine models: answer each request after a random latency of 1..4 cycles.
    initial begin
        forever begin
            @(negedge system_clk);
            if (rd_req && auto_rd) begin
                rd_lat = $urandom_range(1, 4);
                repeat (rd_lat) @(posedge system_clk);
                #1 rd_done_auto = 1'b1;
                @(posedge system_clk);
                #1 rd_done_auto = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge system_clk);
            if (er_req && auto_er) begin
                er_lat = $urandom_range(1, 4);
                repeat (er_lat) @(posedge system_clk);
                #1 er_done_auto = 1'b1;
                @(posedge system_clk);
                #1 er_done_auto = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge system_clk);
            if (pp_req && auto_pp) begin
                pp_lat = $urandom_range(1, 4);
                repeat (pp_lat) @(posedge system_clk);
                #1 pp_done_auto = 1'b1;
                @(posedge system_clk);
                #1 pp_done_auto = 1'b0;
            end
        end
    end

    // Reference model: walk the byte range, never crossing a 256-byte page, and
    // erase a 4 KiB sector the first time a chunk lands in a new one.
    function automatic void model_copy(input logic [31:0] s_in, input logic [31:0] e_in,
                                       input logic [31:0] d_in);
        longint      rem;
        longint      len;
        int          page_off;
        logic [31:0] s, d, sec, last_sec;
        bit          first;
        exp_er.delete();
        exp_rd_addr.delete();
        exp_pp_addr.delete();
        exp_len.delete();
        s        = s_in;
        d        = d_in;
        rem      = longint'(e_in) - longint'(s_in) + 1;
        first    = 1'b1;
        last_sec = '0;
        while (rem > 0) begin
            page_off = int'(d % 32'd256);
            len      = longint'(256 - page_off);
            if (rem < len) len = rem;
            sec = d / 32'd4096;
            if (first || sec != last_sec) begin
                exp_er.push_back(sec * 32'd4096);
                last_sec = sec;
                first    = 1'b0;
            end
            exp_rd_addr.push_back(s);
            exp_pp_addr.push_back(d);
            exp_len.push_back(int'(len));
            s   = s + 32'(len);
            d   = d + 32'(len);
            rem = rem - len;
        end
    endfunction

    function automatic void clear_logs();
        er_log.delete();
        rd_addr_log.delete();
        rd_len_log.delete();
        pp_addr_log.delete();
        pp_len_log.delete();
        saw_busy     = 1'b0;
        saw_mux      = 1'b0;
        saw_busy_low = 1'b0;
    endfunction

    // Index of the first disagreement between logs and model, or -1 when identical.
    function automatic int first_log_diff();
        if (er_log.size() != exp_er.size()) return 1000;
        if (rd_addr_log.size() != exp_len.size()) return 1001;
        if (pp_addr_log.size() != exp_len.size()) return 1002;
        foreach (exp_er[i]) if (er_log[i] !== exp_er[i]) return i;
        foreach (exp_len[i]) begin
            if (rd_addr_log[i] !== exp_rd_addr[i] || rd_len_log[i] != exp_len[i]) return 100 + i;
            if (pp_addr_log[i] !== exp_pp_addr[i] || pp_len_log[i] != exp_len[i]) return 200 + i;
        end
        return -1;
    endfunction

    // Pulse start with the given range and wait (bounded) for completion or error.
    task automatic run_copy(input logic [31:0] s, input logic [31:0] e, input logic [31:0] d,
                            output bit timed_out);
        int cyc;
        clear_logs();
        @(posedge system_clk);
        #1;
        src_start_addr = s;
        src_end_addr   = e;
        dst_start_addr = d;
        start          = 1'b1;
        @(posedge system_clk);
        #1 start = 1'b0;
        cyc       = 0;
        timed_out = 1'b0;
        while (completed_n !== 1'b0 && error !== 1'b1) begin
            @(negedge system_clk);
            cyc++;
            if (cyc > 5000) begin
                timed_out = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        system_reset_n = 1'b0;
        repeat (3) @(posedge system_clk);
        #1;
        tests++;
        if (mux_sel !== 1'b0) begin
            failed++;
            $display("FAIL reset_mux_sel got %0b want 0", mux_sel);
        end
        tests++;
        if ({busy_n, completed_n, error} !== 3'b110) begin
            failed++;
            $display("FAIL reset_status got busy_n/completed_n/error=%b want 110",
                     {busy_n, completed_n, error});
        end
        tests++;
        if ({rd_req, er_req, pp_req} !== 3'b000) begin
            failed++;
            $display("FAIL reset_req got %b want 000", {rd_req, er_req, pp_req});
        end
        tests++;
        if ({rd_addr, er_addr, pp_addr, rd_len, pp_len} !== '0) begin
            failed++;
            $display("FAIL reset_addr_len got rd=%h/%0d er=%h pp=%h/%0d want all zero",
                     rd_addr, rd_len, er_addr, pp_addr, pp_len);
        end
        @(negedge system_clk);
        system_reset_n = 1'b1;
        repeat (2) @(posedge system_clk);
    endtask

    task automatic test_directed_copies();
        bit timed_out;
        int diff;
        for (int i = 0; i < 3; i++) begin
            model_copy(d_src[i], d_end[i], d_dst[i]);
            bad_pulse = 0;
            run_copy(d_src[i], d_end[i], d_dst[i], timed_out);
            tests++;
            if (timed_out) begin
                failed++;
                $display("FAIL dir%0d_finish got no completion within 5000 cycles want done", i);
            end
            tests++;
            if ({completed_n, error, busy_n, mux_sel} !== 4'b0010) begin
                failed++;
                $display("FAIL dir%0d_status got completed_n/error/busy_n/mux_sel=%b want 0010",
                         i, {completed_n, error, busy_n, mux_sel});
            end
            tests++;
            if (!saw_busy) begin
                failed++;
                $display("FAIL dir%0d_busy got never busy with mux_sel=1 want seen", i);
            end
            tests++;
            if (er_log.size() != d_ner[i] || pp_addr_log.size() != d_nch[i]) begin
                failed++;
                $display("FAIL dir%0d_counts got erases=%0d chunks=%0d want %0d/%0d", i,
                         er_log.size(), pp_addr_log.size(), d_ner[i], d_nch[i]);
            end
            diff = first_log_diff();
            tests++;
            if (diff != -1) begin
                failed++;
                $display("FAIL dir%0d_log got first difference code %0d want none", i, diff);
            end
            tests++;
            if (bad_pulse != 0) begin
                failed++;
                $display("FAIL dir%0d_pulses got %0d protocol violations want 0", i, bad_pulse);
            end
        end
    endtask

    task automatic test_bad_range();
        int cnt;
        clear_logs();
        @(posedge system_clk);
        #1;
        src_start_addr = 32'h0000_0200;
        src_end_addr   = 32'h0000_0100;
        dst_start_addr = 32'h0000_4000;
        start          = 1'b1;
        @(posedge system_clk);
        #1 start = 1'b0;
        cnt = 0;
        while (error !== 1'b1 && cnt < 10) begin
            @(negedge system_clk);
            cnt++;
        end
        tests++;
        if (error !== 1'b1 || cnt != 2) begin
            failed++;
            $display("FAIL bad_range_error got error=%0b after %0d cycles want 1 after 2",
                     error, cnt);
        end
        repeat (3) @(negedge system_clk);
        tests++;
        if (er_log.size() + rd_addr_log.size() + pp_addr_log.size() != 0) begin
            failed++;
            $display("FAIL bad_range_req got %0d requests want 0",
                     er_log.size() + rd_addr_log.size() + pp_addr_log.size());
        end
        tests++;
        if (saw_mux || saw_busy_low || completed_n !== 1'b1) begin
            failed++;
            $display("FAIL bad_range_pins got mux_seen=%0b busy_seen=%0b completed_n=%0b want 0/0/1",
                     saw_mux, saw_busy_low, completed_n);
        end
    endtask

    task automatic test_random_copies();
        bit          timed_out;
        int          diff;
        int          len;
        logic [31:0] s, e, d;
        for (int i = 0; i < 6; i++) begin
            if (i == 0) begin
                // Destination wraps past the top of the address space.
                s = $urandom_range(0, 32'h7FFF_FFFF);
                e = s + 32'd299;
                d = 32'hFFFF_FF80;
            end else begin
                len = $urandom_range(1, 1100);
                s   = $urandom_range(0, 32'hFFFF_0000);
                e   = s + 32'(len) - 32'd1;
                d   = $urandom;
            end
            model_copy(s, e, d);
            bad_pulse = 0;
            run_copy(s, e, d, timed_out);
            tests++;
            if (timed_out || completed_n !== 1'b0 || error !== 1'b0) begin
                failed++;
                $display("FAIL rand%0d_status got timeout=%0b completed_n=%0b error=%0b want 0/0/0",
                         i, timed_out, completed_n, error);
            end
            diff = first_log_diff();
            tests++;
            if (diff != -1 || bad_pulse != 0) begin
                failed++;
                $display("FAIL rand%0d_log src=%h end=%h dst=%h got diff code %0d violations %0d want -1/0",
                         i, s, e, d, diff, bad_pulse);
            end
        end
    endtask

    task automatic test_timeout();
        int cnt;
        auto_pp = 1'b0;
        clear_logs();
        @(posedge system_clk);
        #1;
        src_start_addr = 32'h0000_0010;
        src_end_addr   = 32'h0000_001F;
        dst_start_addr = 32'h0000_7000;
        start          = 1'b1;
        @(posedge system_clk);
        #1 start = 1'b0;
        cnt = 0;
        while (pp_req !== 1'b1 && cnt < 300) begin
            @(negedge system_clk);
            cnt++;
        end
        tests++;
        if (pp_req !== 1'b1) begin
            failed++;
            $display("FAIL timeout_pp_req got no pp_req within 300 cycles want pp_req");
        end
        cnt = 0;
        while (error !== 1'b1 && cnt < 300) begin
            @(negedge system_clk);
            cnt++;
        end
        tests++;
        if (error !== 1'b1 || cnt != TIMEOUT + 1) begin
            failed++;
            $display("FAIL timeout_latency got error=%0b after %0d cycles want 1 after %0d",
                     error, cnt, TIMEOUT + 1);
        end
        tests++;
        if ({mux_sel, busy_n, completed_n} !== 3'b011) begin
            failed++;
            $display("FAIL timeout_pins got mux_sel/busy_n/completed_n=%b want 011",
                     {mux_sel, busy_n, completed_n});
        end
        auto_pp = 1'b1;
        repeat (3) @(posedge system_clk);
    endtask

    task automatic test_abort_and_busy_start();
        int cnt;
        auto_rd = 1'b0;
        clear_logs();
        @(posedge system_clk);
        #1;
        src_start_addr = 32'h0000_0100;
        src_end_addr   = 32'h0000_01FF;
        dst_start_addr = 32'h0000_5000;
        start          = 1'b1;
        @(posedge system_clk);
        #1 start = 1'b0;
        cnt = 0;
        while (rd_req !== 1'b1 && cnt < 300) begin
            @(negedge system_clk);
            cnt++;
        end
        tests++;
        if (rd_req !== 1'b1) begin
            failed++;
            $display("FAIL abort_rd_req got no rd_req within 300 cycles want rd_req");
        end
        // A second start while busy must not disturb the copy in flight.
        @(posedge system_clk);
        #1;
        src_start_addr = 32'h0000_9000;
        src_end_addr   = 32'h0000_9FFF;
        dst_start_addr = 32'h0001_0000;
        start          = 1'b1;
        @(posedge system_clk);
        #1 start = 1'b0;
        @(posedge system_clk);
        #1;
        abort       = 1'b1;
        rd_done_man = 1'b1;
        @(posedge system_clk);
        #1;
        abort       = 1'b0;
        rd_done_man = 1'b0;
        repeat (6) @(negedge system_clk);
        tests++;
        if ({error, mux_sel, busy_n} !== 3'b101) begin
            failed++;
            $display("FAIL abort_pins got error/mux_sel/busy_n=%b want 101",
                     {error, mux_sel, busy_n});
        end
        tests++;
        if (pp_addr_log.size() != 0) begin
            failed++;
            $display("FAIL abort_no_pp got %0d pp_req want 0", pp_addr_log.size());
        end
        tests++;
        if (rd_addr_log.size() != 1 || er_log.size() != 1 ||
            (rd_addr_log.size() > 0 && rd_addr_log[0] !== 32'h0000_0100)) begin
            failed++;
            $display("FAIL busy_start_ignored got rd=%0d er=%0d requests want 1 rd @00000100 and 1 er",
                     rd_addr_log.size(), er_log.size());
        end
        auto_rd = 1'b1;
        repeat (3) @(posedge system_clk);
    endtask

    task automatic test_reset_mid_copy();
        clear_logs();
        @(posedge system_clk);
        #1;
        src_start_addr = 32'h0000_0000;
        src_end_addr   = 32'h0000_0FFF;
        dst_start_addr = 32'h0000_0000;
        start          = 1'b1;
        @(posedge system_clk);
        #1 start = 1'b0;
        repeat (30) @(posedge system_clk);
        #1;
        tests++;
        if ({mux_sel, busy_n} !== 2'b10) begin
            failed++;
            $display("FAIL midreset_pre got mux_sel/busy_n=%b want 10", {mux_sel, busy_n});
        end
        system_reset_n = 1'b0;
        #2;
        tests++;
        if ({mux_sel, busy_n, completed_n, error, rd_req, er_req, pp_req} !== 7'b0110000 ||
            {rd_addr, er_addr, pp_addr, rd_len, pp_len} !== '0) begin
            failed++;
            $display("FAIL midreset_async got mux/busy_n/compl_n/err/reqs=%b rd=%h er=%h pp=%h want 0110000 and zeros",
                     {mux_sel, busy_n, completed_n, error, rd_req, er_req, pp_req},
                     rd_addr, er_addr, pp_addr);
        end
        @(negedge system_clk);
        system_reset_n = 1'b1;
        repeat (10) @(posedge system_clk);
    endtask

    initial begin
        test_reset();
        test_directed_copies();
        test_bad_range();
        test_random_copies();
        test_timeout();
        test_abort_and_busy_start();
        test_reset_mid_copy();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit got still running want finished");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/spi_copy_sequencer.md
# spi_copy_sequencer

Control block that copies a byte range from SPI flash ROM A to ROM B. It takes one start request and splits the range into page-aligned chunks. For each chunk it sequences the flash read engine, the sector-erase engine and the page-program engine in turn, with a watchdog on every engine wait. It owns the board mux-select output and the busy/completed/error status, so the top level only connects engines and pins.

## Interface
Parameters:
- ADDR_W, 32, flash address width
- PAGE_BYTES, 256, program page size (power of two)
- SECTOR_BYTES, 4096, erase sector size (power of two, ≥ PAGE_BYTES)
- SETTLE_CYC, 16, mux settling delay in cycles
- TIMEOUT_CYC, 2^24, maximum wait for any engine done

Ports:
- system_clk  in  1  clock
- system_reset_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle start pulse
- abort  in  1  one-cycle abort pulse
- src_start_addr  in  ADDR_W  first ROM A byte
- src_end_addr  in  ADDR_W  last ROM A byte (inclusive)
- dst_start_addr  in  ADDR_W  first ROM B byte
- rd_req  out  1  read command pulse
- rd_addr  out  ADDR_W  read address
- rd_len  out  9  read byte count, 1..PAGE_BYTES
- rd_done  in  1  read chunk buffered
- er_req  out  1  sector erase pulse
- er_addr  out  ADDR_W  sector base address
- er_done  in  1  erase complete
- pp_req  out  1  page program pulse
- pp_addr  out  ADDR_W  program address
- pp_len  out  9  program byte count
- pp_done  in  1  program complete
- mux_sel  out  1  flash bus owned by FPGA
- busy_n  out  1  low while a copy is in progress
- completed_n  out  1  low after a successful copy
- error  out  1  high after a failed or aborted copy

## Operation
- States: IDLE, SETTLE, CHUNK, ERASE, WAIT_ER, READ, WAIT_RD, PROG, WAIT_PP, NEXT, DONE, FAIL.
- IDLE + start:
  - Latch all three addresses.
  - Clear completed_n and error to their inactive values.
  - If src_end_addr < src_start_addr, go to FAIL. Otherwise set remaining = end − start + 1 (ADDR_W+1 bits, so a full 2^32 span is representable) and go to SETTLE.
- SETTLE: mux_sel=1; wait SETTLE_CYC cycles, then go to CHUNK.
- CHUNK: len = min(remaining, PAGE_BYTES − (dst mod PAGE_BYTES)). Program operations never cross a page boundary.
  - If dst's sector differs from last_erased (or this is the first chunk), go to ERASE. Otherwise go to READ.
- ERASE: pulse er_req with er_addr = dst & ~(SECTOR_BYTES−1), then go to WAIT_ER. On er_done, record last_erased and go to READ.
- READ: pulse rd_req with (src, len), then go to WAIT_RD. On rd_done go to PROG.
- PROG: pulse pp_req with (dst, len), then go to WAIT_PP. On pp_done go to NEXT.
- NEXT: src += len, dst += len (modulo 2^ADDR_W), remaining −= len. If remaining = 0 go to DONE, else go to CHUNK.
- DONE: mux_sel=0, busy_n=1, completed_n=0, then go to IDLE. completed_n is held low until the next start.
- FAIL: mux_sel=0, busy_n=1, error=1, then go to IDLE. error is held high until the next start.
- Reset values: mux_sel=0, busy_n=1, completed_n=1, error=0, all req=0, all addr/len=0; state IDLE.

## Timing
- Each req is exactly one cycle wide. The matching addr/len outputs are stable from the req cycle until the engine's done is sampled.
- done inputs are honoured only in the matching WAIT state and are ignored elsewhere. The minimum accepted latency is req+1.
- The timeout counter clears on entry to each WAIT state. If it reaches TIMEOUT_CYC, go to FAIL.
- abort in any state other than IDLE, DONE or FAIL goes to FAIL on the next cycle. If abort and done arrive in the same cycle, abort wins.
- start is ignored while busy_n=0.
- Per-chunk overhead is at most 6 cycles plus the engine latencies.
- Reset mid-copy returns the block to reset values immediately. Partial ROM B contents are not the block's concern.

## Structure
- Shared package holds the state encoding, the default PAGE_BYTES/SECTOR_BYTES, and the len width (9).
- One sub-module: spi_wait_timer, a loadable down-counter with clear, enable and expired outputs. It is reused for both SETTLE and the timeout.
- Chunk arithmetic and sector tracking stay inline.

## Test plan
- src 0x01000F00..0x01000F05, dst 0x03000000 → one erase @0x03000000, rd/pp len 6, then completed_n=0, busy_n=1.
- src 0x0..0x2FF, dst 0x080 → chunks of 128, 256, 256, 128 at dst 0x080/0x100/0x200/0x300, with one erase only.
- dst 0x0F80, length 0x100 → erases @0x0000 and @0x1000; chunks of 128 + 128.
- src_end < src_start → error=1 the cycle after FAIL, with no req issued and mux_sel staying 0.
- pp_done withheld with TIMEOUT_CYC=100 → FAIL 100 cycles after entering WAIT_PP; error=1, mux_sel=0.
- abort in the same cycle as rd_done → FAIL, no pp_req; a new start while busy is ignored.
